// File: rtl/noc_local_endpoint.sv
// noc_local_endpoint: router local-port endpoint with credit-based VC-locked TX and round-robin RX FIFOs
module noc_local_endpoint #(
  parameter int CREDITS = 4,
  parameter int FLIT_W = 35
) (
  input  logic              clk,
  input  logic              RST_,
  input  logic [FLIT_W-1:0] src_data,
  input  logic              src_vch,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [FLIT_W-1:0] ODATA,
  output logic              OVALID,
  output logic              OVCH,
  input  logic [1:0]        IACK,
  output logic [1:0]        OLCK,
  input  logic [FLIT_W-1:0] IDATA,
  input  logic              IVALID,
  input  logic              IVCH,
  output logic [1:0]        ORDY,
  output logic [1:0]        OACK,
  output logic [FLIT_W-1:0] snk_data,
  output logic              snk_vch,
  output logic              snk_valid,
  input  logic              snk_ready,
  output logic              err
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = $clog2(CREDITS);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OPEN = 1'b1;
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  localparam logic [PW-1:0] PLAST = PW'(CREDITS - 1);
  logic [0:0] state_q, state_d;
  logic vc_q, vc_d;
  logic [1:0][CW-1:0] credit_q, credit_d, cnt_q, cnt_d;
  logic [1:0][PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FLIT_W-1:0] odata_q, mem_q [2][CREDITS];
  logic ovalid_q, ovch_q, rr_q, sel, tgt, bad, send, err_q;
  logic [1:0] ftype, send_v, ack_ovf, oack_q, wr, wr_ok, pop, full;
  assign ftype = src_data[FLIT_W-1 -: 2];
  assign tgt = (state_q == OPEN) ? vc_q : src_vch;
  assign src_ready = src_valid && credit_q[tgt] != '0;
  // Heads (type bit 0 set) are only legal when idle, body/tail only while a packet is open.
  assign bad = src_ready && ((state_q == OPEN) == ftype[0]);
  assign send = src_ready && !bad;
  assign send_v = {send && tgt, send && !tgt};
  always_comb begin
    state_d = !send ? state_q
            : (state_q == IDLE && ftype == 2'b01) ? OPEN
            : (state_q == OPEN && ftype == 2'b10) ? IDLE : state_q;
    vc_d = (send && state_q == IDLE) ? src_vch : vc_q;
  end
  assign sel = (cnt_q[rr_q] != '0) ? rr_q : !rr_q;
  assign snk_valid = cnt_q[sel] != '0;
  assign snk_data = snk_valid ? mem_q[sel][rp_q[sel]] : '0;
  assign snk_vch = snk_valid && sel;
  assign pop = {snk_valid && snk_ready && sel, snk_valid && snk_ready && !sel};
  assign wr = {IVALID && IVCH, IVALID && !IVCH};
  for (genvar v = 0; v < 2; v++) begin : g_vc
    assign ack_ovf[v] = IACK[v] && credit_q[v] == CMAX && !send_v[v];
    assign credit_d[v] = ack_ovf[v] ? credit_q[v] : credit_q[v] - CW'(send_v[v]) + CW'(IACK[v]);
    assign full[v] = cnt_q[v] == CMAX;
    assign wr_ok[v] = wr[v] && (!full[v] || pop[v]);
    assign cnt_d[v] = cnt_q[v] + CW'(wr_ok[v]) - CW'(pop[v]);
    assign wp_d[v] = !wr_ok[v] ? wp_q[v] : (wp_q[v] == PLAST) ? '0 : wp_q[v] + PW'(1);
    assign rp_d[v] = !pop[v] ? rp_q[v] : (rp_q[v] == PLAST) ? '0 : rp_q[v] + PW'(1);
    assign OLCK[v] = (state_q == OPEN) && vc_q == v[0];
  end
  assign ORDY = ~full;
  assign ODATA = odata_q;
  assign OVALID = ovalid_q;
  assign OVCH = ovch_q;
  assign OACK = oack_q;
  assign err = err_q;
  always_ff @(posedge clk) begin
    if (RST_) begin
      state_q <= IDLE;
      vc_q <= 1'b0;
      credit_q <= {2{CMAX}};
      odata_q <= '0;
      ovalid_q <= 1'b0;
      ovch_q <= 1'b0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      rr_q <= 1'b0;
      oack_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vc_q <= vc_d;
      credit_q <= credit_d;
      odata_q <= send ? src_data : odata_q;
      ovalid_q <= send;
      ovch_q <= send ? tgt : ovch_q;
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      rr_q <= (|pop) ? !sel : rr_q;
      oack_q <= pop;
      err_q <= err_q || bad || (|ack_ovf) || (|(wr & ~wr_ok));
    end
  end
  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++)
      if (wr_ok[v]) mem_q[v][wp_q[v]] <= IDATA;
  end
endmodule
